mole_timer: RTL and testbench



---
 rtl/mole_timer_if.sv | 33 +++
 rtl/mole_timer.sv | 151 +++++++++++++++
 tb/tb_mole_timer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mole_timer_if.sv
// mole_timer_if -- strobe/status bundle between the mole LED controller and
// the per-mole lifetime timer.
//
//   enable        controller -> timer  game active
//   start_timer   controller -> timer  one-cycle strobe, (re)start window
//   hit_pulse     controller -> timer  one-cycle strobe, current mole hit
//   timeout_pulse timer -> controller  one-cycle strobe, window expired unhit
//   running       timer -> controller  window counting
//   level         timer -> controller  difficulty level 0..7
//   time_left     timer -> controller  remaining cycles, 0 when idle
//
// master = LED controller side, slave = timer side.
interface mole_timer_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             start_timer;
    logic             hit_pulse;
    logic             timeout_pulse;
    logic             running;
    logic [2:0]       level;
    logic [CNT_W-1:0] time_left;

    modport master (
        output enable, start_timer, hit_pulse,
        input  timeout_pulse, running, level, time_left
    );

    modport slave (
        input  enable, start_timer, hit_pulse,
        output timeout_pulse, running, level, time_left
    );
endinterface

// File: rtl/mole_timer.sv
// mole_timer -- per-mole lifetime timer with difficulty ramp.
//
// A start strobe loads a down-counter with W-1, where
// W = max(BASE_TICKS - level*STEP_TICKS, MIN_TICKS). If the counter expires
// without a hit, timeout_pulse fires for one cycle. Every HITS_PER_LEVEL
// counted hits raise the level (saturating at MAX_LEVEL), shortening W.
//
// Ports:
//   clk_game  game clock
//   rst       asynchronous, active-high reset
//   bus       mole_timer_if.slave (enable/start_timer/hit_pulse in;
//             timeout_pulse/running/level/time_left out, all registered)
//
// Configuration macro: MOLE_TIMER_RAMP_EN
//   defined   -> hit counter and level ramp present
//   undefined -> level tied to 0, W = BASE_TICKS always; hits still stop
//                the window
module mole_timer #(
    parameter int CNT_W          = 16,
    parameter int BASE_TICKS     = 1000,
    parameter int STEP_TICKS     = 100,
    parameter int MIN_TICKS      = 200,
    parameter int HITS_PER_LEVEL = 4,
    parameter int MAX_LEVEL      = 7
) (
    input  logic          clk_game,
    input  logic          rst,
    mole_timer_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] window;

`ifdef MOLE_TIMER_RAMP_EN
    localparam int XW    = CNT_W + 3;
    localparam int HIT_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    logic [2:0]       level_q, level_d;
    logic [HIT_W-1:0] hits_q, hits_d;
    logic [XW-1:0]    step_prod;

    // Product and sum are formed in CNT_W+3 bits so neither can wrap; the
    // floor test is done before subtracting, so W never underflows.
    always_comb begin
        step_prod = XW'(STEP_TICKS) * XW'(level_q);
        if (step_prod + XW'(MIN_TICKS) >= XW'(BASE_TICKS)) begin
            window = CNT_W'(MIN_TICKS);
        end else begin
            window = CNT_W'(XW'(BASE_TICKS) - step_prod);
        end
    end
`else
    always_comb begin
        window = CNT_W'(BASE_TICKS);
    end
`endif

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`ifdef MOLE_TIMER_RAMP_EN
        level_d   = level_q;
        hits_d    = hits_q;
`endif
        if (!bus.enable) begin
            // Game stopped: abort silently and drop difficulty, from any state.
            state_d = IDLE;
            cnt_d   = '0;
`ifdef MOLE_TIMER_RAMP_EN
            level_d = '0;
            hits_d  = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    // hit_pulse is ignored here: there is no live mole.
                    if (bus.start_timer) begin
                        state_d = RUN;
                        cnt_d   = window - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (bus.hit_pulse) begin
                        // A hit beats a simultaneous start or expiry.
                        state_d = IDLE;
                        cnt_d   = '0;
`ifdef MOLE_TIMER_RAMP_EN
                        if (hits_q == HIT_W'(HITS_PER_LEVEL - 1)) begin
                            hits_d = '0;
                            if (level_q < 3'(MAX_LEVEL)) begin
                                level_d = level_q + 3'd1;
                            end
                        end else begin
                            hits_d = hits_q + HIT_W'(1);
                        end
`endif
                    end else if (bus.start_timer) begin
                        cnt_d = window - CNT_W'(1);
                    end else if (cnt_q == '0) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_game or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`ifdef MOLE_TIMER_RAMP_EN
            level_q   <= '0;
            hits_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`ifdef MOLE_TIMER_RAMP_EN
            level_q   <= level_d;
            hits_q    <= hits_d;
`endif
        end
    end

    // cnt_q is cleared whenever the FSM leaves RUN, so it doubles as time_left.
    assign bus.timeout_pulse = timeout_q;
    assign bus.running       = (state_q == RUN);
    assign bus.time_left     = cnt_q;
`ifdef MOLE_TIMER_RAMP_EN
    assign bus.level         = level_q;
`else
    assign bus.level         = 3'd0;
`endif
endmodule

// File: tb/tb_mole_timer.sv
// tb_mole_timer -- self-checking bench for mole_timer.
// Small window parameters; a transaction-level reference model tracks the
// live window (length, age) and the total of counted hits, deriving level
// as min(counted / HITS, MAX) and time_left as W-1-age.
module tb_mole_timer;
    localparam int CNT_W = 16;
    localparam int BASE  = 10;
    localparam int STEP  = 2;
    localparam int MINT  = 4;
    localparam int HITS  = 2;
    localparam int MAXL  = 7;
`ifdef MOLE_TIMER_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mole_timer_if #(.CNT_W(CNT_W)) bus ();

    mole_timer #(
        .CNT_W(CNT_W), .BASE_TICKS(BASE), .STEP_TICKS(STEP),
        .MIN_TICKS(MINT), .HITS_PER_LEVEL(HITS), .MAX_LEVEL(MAXL)
    ) dut (
        .clk_game(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_run, m_age, m_w, m_counted, m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_level();
        int l;
        if (!RAMP) return 0;
        l = m_counted / HITS;
        return (l > MAXL) ? MAXL : l;
    endfunction

    function automatic int window_of(input int l);
        int w;
        w = BASE - l * STEP;
        return (w < MINT) ? MINT : w;
    endfunction

    function automatic int m_tl();
        return m_run ? (m_w - 1 - m_age) : 0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_age = 0; m_w = 0; m_counted = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit en, input bit st, input bit hit);
        m_pulse = 0;
        if (!en) begin
            m_run = 0;
            m_counted = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_w = window_of(m_level()); m_age = 0;
            end
        end else if (hit) begin
            m_run = 0;
            m_counted++;
        end else if (st) begin
            m_w = window_of(m_level()); m_age = 0;
        end else if (m_age == m_w - 1) begin
            m_run = 0;
            m_pulse = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".running"},   32'(bus.running),       32'(m_run));
        check({tag, ".timeout"},   32'(bus.timeout_pulse), 32'(m_pulse));
        check({tag, ".level"},     32'(bus.level),         32'(m_level()));
        check({tag, ".time_left"}, 32'(bus.time_left),     32'(m_tl()));
    endtask

    task automatic cycle(input bit en, input bit st, input bit hit);
        bus.enable      = en;
        bus.start_timer = st;
        bus.hit_pulse   = hit;
        @(posedge clk);
        model_step(en, st, hit);
        #1;
        check_outputs("cyc");
    endtask

    // Idles until timeout_pulse; the count of cycles since the start edge
    // must equal the expected window length.
    task automatic wait_timeout(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (bus.timeout_pulse !== 1'b1 && n < 50) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    task automatic start_hit();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        bus.enable = 1'b0; bus.start_timer = 1'b0; bus.hit_pulse = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic timeout.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("start_tl", 32'(bus.time_left), 32'd9);
        wait_timeout("basic_window", 10);
        cycle(1'b1, 1'b0, 1'b0);

        // Hit at time_left=5, then a second start+hit, then the next window.
        cycle(1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        check("tl_before_hit", 32'(bus.time_left), 32'd5);
        cycle(1'b1, 1'b0, 1'b1);
        check("level_one_hit", 32'(bus.level), 32'd0);
        start_hit();
        check("level_two_hits", 32'(bus.level), RAMP ? 32'd1 : 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        wait_timeout("level1_window", RAMP ? 8 : 10);

        // Floor and saturation.
        cycle(1'b0, 1'b0, 1'b0);
        repeat (6) start_hit();
        check("level_6hits", 32'(bus.level), RAMP ? 32'd3 : 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        wait_timeout("level3_window", RAMP ? 4 : 10);
        repeat (2) start_hit();
        check("level_8hits", 32'(bus.level), RAMP ? 32'd4 : 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        wait_timeout("level4_window", RAMP ? 4 : 10);
        repeat (6) start_hit();
        check("level_14hits", 32'(bus.level), RAMP ? 32'd7 : 32'd0);
        repeat (4) start_hit();
        check("level_sat", 32'(bus.level), RAMP ? 32'd7 : 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        wait_timeout("level7_window", RAMP ? 4 : 10);

        // Restart at time_left=3, level 0.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && m_tl() != 3; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("restart_tl", 32'(bus.time_left), 32'd9);
        wait_timeout("restart_window", 10);

        // Hit in the expiry cycle: no pulse, hit counted.
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && m_tl() != 0; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        check("expiry_hit_pulse", 32'(bus.timeout_pulse), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        start_hit();
        check("expiry_hit_counted", 32'(bus.level), RAMP ? 32'd1 : 32'd0);

        // Start together with hit in RUN: hit counted, stays idle.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        check("start_hit_idle", 32'(bus.running), 32'd0);

        // Enable drop mid-run; start ignored while disabled.
        cycle(1'b0, 1'b0, 1'b0);
        repeat (4) start_hit();
        check("level_before_abort", 32'(bus.level), RAMP ? 32'd2 : 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("abort_level", 32'(bus.level), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check("disabled_start", 32'(bus.running), 32'd0);
        repeat (12) cycle(1'b1, 1'b0, 1'b0);

        // Async reset between edges, mid-run.
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) cycle(1'b1, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 39) != 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
